ex_mdu: RTL and testbench
=========================

// Module: ex_mdu
// PURPOSE
//  Parametrised multi-cycle RV32M multiply/divide unit, sitting beside the EX stage ALU.
//  Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op and holds the pipeline via stallreq_o.
//  Returns a registered result plus write-back tag; dividing and, optionally, multiplying are iterative.
// PARAMETERS
//  XLEN      32  operand/result width (>=8, even)
//  MUL_ITER  0   0: single-cycle registered multiply; 1: iterative shift-add multiply (XLEN iterations)
//  ADDR_W    5   width of destination register address
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-high (`RstEnable), one clock
//  start_i      in   1       issue op; sampled only in IDLE
//  annul_i      in   1       abort in-flight op (flush); sync, highest priority after rst
//  op_i         in   3       `MDU_* op code (package)
//  rs1_i        in   XLEN    operand 1 (dividend / multiplicand)
//  rs2_i        in   XLEN    operand 2 (divisor / multiplier)
//  wd_i         in   ADDR_W  destination register
//  stallreq_o   out  1       request EX stall while op is pending
//  done_o       out  1       one-cycle pulse: result_o/wd_o valid
//  result_o     out  XLEN    result
//  wd_o         out  ADDR_W  destination, captured at start
//  wreg_o       out  1       write enable, equals done_o
// BEHAVIOUR
//  Reset: state=IDLE; done_o, wreg_o, result_o, wd_o = 0; internal counters/accumulators 0. Same on reset mid-op.
//  FSM: IDLE, CALC, FIX, DONE.
//   IDLE: start_i & !annul_i -> capture op, |operands|, sign flags, wd_i.
//     DIV/REM with rs2==0 -> DONE: DIV/DIVU = all-ones, REM/REMU = rs1.
//     DIV/REM with rs1==most-negative & rs2==-1 (signed) -> DONE: DIV = rs1, REM = 0.
//     MUL* with MUL_ITER=0 -> DONE with full 2*XLEN product, pick low/high half.
//     otherwise -> CALC, count=XLEN.
//   CALC: one bit per cycle (restoring divide / shift-add multiply) on unsigned magnitudes; count--;
//     count reaches 1 during this cycle -> FIX.
//   FIX: apply sign: quotient neg if signs differ; remainder takes dividend sign;
//     MULH/MULHSU 2*XLEN two's-complement negate when needed -> DONE.
//   DONE: done_o=wreg_o=1 for exactly one cycle, result_o valid -> IDLE.
//  Latency (start sampled at cycle 0): fast paths done_o at cycle 1; iterative ops done_o at cycle XLEN+2.
//  stallreq_o = (IDLE & start_i & !annul_i) | CALC | FIX; low in DONE so pipeline advances with result.
//  start_i outside IDLE is ignored (no queuing); EX must hold operands stable only in start cycle.
//  annul_i in any state: next state IDLE, done_o not asserted; annul_i with start_i in IDLE: op dropped.
//  result_o holds last value after DONE until next DONE; wd_o likewise.
//  Arithmetic: MULHSU treats rs1 signed, rs2 unsigned; MULHU/DIVU/REMU fully unsigned; all XLEN-wide wrap.
// STRUCTURE
//  define.v gains: `MDU_MUL..`MDU_REMU encodings (3'd0..3'd7), `MduOpBus, FSM state codes.
//  Sub-module mdu_step: combinational one-iteration datapath (trial subtract / conditional add),
//    XLEN-parametrised, instantiated once; FSM, counter, sign fixup stay in ex_mdu.
// TESTING
//  DIV rs1=-20 rs2=3 -> done_o at cycle 34, result=-6 (0xFFFFFFFA); REM same -> -2.
//  DIVU rs1=7 rs2=0 -> done_o at cycle 1, result=0xFFFFFFFF; REMU -> 7.
//  DIV rs1=0x80000000 rs2=0xFFFFFFFF -> cycle 1, result=0x80000000; REM -> 0.
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF (both MUL_ITER=0/1).
//  annul_i at cycle 10 of a DIV -> no done_o, stallreq_o low at 11, new start accepted at 11.
//  start_i held high during CALC with different operands -> ignored; rst at cycle 5 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - RV32M multiply/divide op codes, FSM states and operand-sign decode helpers
package ex_mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic rs1_signed(input mdu_op_e op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic rs2_signed(input mdu_op_e op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// rtl/ex_mdu_if.sv - EX-stage issue/result bundle between pipeline and multiply/divide unit
interface ex_mdu_if import ex_mdu_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) ();
    logic              start_i;
    logic              annul_i;
    mdu_op_e           op_i;
    logic [XLEN-1:0]   rs1_i;
    logic [XLEN-1:0]   rs2_i;
    logic [ADDR_W-1:0] wd_i;
    logic              stallreq_o;
    logic              done_o;
    logic [XLEN-1:0]   result_o;
    logic [ADDR_W-1:0] wd_o;
    logic              wreg_o;

    modport master (
        output start_i, annul_i, op_i, rs1_i, rs2_i, wd_i,
        input  stallreq_o, done_o, result_o, wd_o, wreg_o
    );

    modport slave (
        input  start_i, annul_i, op_i, rs1_i, rs2_i, wd_i,
        output stallreq_o, done_o, result_o, wd_o, wreg_o
    );
endinterface

// File: rtl/ex_mdu_step.sv
// rtl/ex_mdu_step.sv - one iteration of restoring divide or shift-add multiply on {hi,lo}
// Divide: hi = partial remainder, lo = dividend shifting out / quotient shifting in.
module ex_mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic [XLEN:0]   sum;

    always_comb begin
        shifted = {hi, lo[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, b};
        sum     = {1'b0, hi} + ({1'b0, b} & {(XLEN+1){lo[0]}});
        if (is_div) begin
            // Borrow means the trial subtract failed: keep the shifted remainder.
            if (diff[XLEN+1]) begin
                hi_nxt = shifted[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end else begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - multi-cycle RV32M multiply/divide unit beside the EX ALU
// Special-case divides (and multiplies when MUL_ITER=0) finish in one cycle; the rest iterate XLEN steps.
module ex_mdu import ex_mdu_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int MUL_ITER = 0,
    parameter int ADDR_W   = 5
) (
    input logic   clk,
    input logic   rst,
    ex_mdu_if.slave mdu
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state, state_nxt;
    mdu_op_e           op_q;
    logic [XLEN-1:0]   hi, lo, b_q, hi_step, lo_step;
    logic [CNT_W-1:0]  count;
    logic              neg_q, neg_r;
    logic [ADDR_W-1:0] wd_q, wd_out;
    logic [XLEN-1:0]   result_q;

    logic              issue, is_div, s1, s2, div_zero, div_ovf, fast;
    logic [XLEN-1:0]   abs1, abs2, fast_res, fix_res;
    logic [2*XLEN-1:0] fast_prod, fix_prod;

    ex_mdu_step #(.XLEN(XLEN)) u_step (
        .is_div (op_is_div(op_q)),
        .hi     (hi),
        .lo     (lo),
        .b      (b_q),
        .hi_nxt (hi_step),
        .lo_nxt (lo_step)
    );

    always_comb begin
        issue    = (state == ST_IDLE) && mdu.start_i && !mdu.annul_i;
        is_div   = op_is_div(mdu.op_i);
        s1       = rs1_signed(mdu.op_i) & mdu.rs1_i[XLEN-1];
        s2       = rs2_signed(mdu.op_i) & mdu.rs2_i[XLEN-1];
        abs1     = s1 ? -mdu.rs1_i : mdu.rs1_i;
        abs2     = s2 ? -mdu.rs2_i : mdu.rs2_i;
        div_zero = is_div && (mdu.rs2_i == '0);
        div_ovf  = is_div && rs1_signed(mdu.op_i) && (mdu.rs1_i == MOST_NEG) && (mdu.rs2_i == '1);
        fast_prod = {{XLEN{s1}}, mdu.rs1_i} * {{XLEN{s2}}, mdu.rs2_i};
        fast     = div_zero || div_ovf || (!is_div && (MUL_ITER == 0));

        // op bit 1 separates REM/REMU (set) from DIV/DIVU
        if (div_zero)                  fast_res = mdu.op_i[1] ? mdu.rs1_i : '1;
        else if (div_ovf)              fast_res = mdu.op_i[1] ? '0 : mdu.rs1_i;
        else if (MUL_ITER != 0)        fast_res = '0;
        else if (mdu.op_i == MDU_MUL)  fast_res = fast_prod[XLEN-1:0];
        else                           fast_res = fast_prod[2*XLEN-1:XLEN];

        fix_prod = neg_q ? -{hi, lo} : {hi, lo};
        if (op_is_div(op_q))           fix_res = op_q[1] ? (neg_r ? -hi : hi) : (neg_q ? -lo : lo);
        else if (op_q == MDU_MUL)      fix_res = fix_prod[XLEN-1:0];
        else                           fix_res = fix_prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (issue) state_nxt = fast ? ST_DONE : ST_CALC;
            ST_CALC: if (count == CNT_W'(1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (mdu.annul_i) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= MDU_MUL;
            hi       <= '0;
            lo       <= '0;
            b_q      <= '0;
            count    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            wd_q     <= '0;
            wd_out   <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (issue) begin
                    op_q  <= mdu.op_i;
                    wd_q  <= mdu.wd_i;
                    neg_q <= s1 ^ s2;
                    neg_r <= s1;
                    count <= CNT_W'(XLEN);
                    hi    <= '0;
                    lo    <= is_div ? abs1 : abs2;
                    b_q   <= is_div ? abs2 : abs1;
                    if (fast) begin
                        result_q <= fast_res;
                        wd_out   <= mdu.wd_i;
                    end
                end
                ST_CALC: if (!mdu.annul_i) begin
                    hi    <= hi_step;
                    lo    <= lo_step;
                    count <= count - CNT_W'(1);
                end
                ST_FIX: if (!mdu.annul_i) begin
                    result_q <= fix_res;
                    wd_out   <= wd_q;
                end
                default: ;
            endcase
        end
    end

    assign mdu.stallreq_o = issue || (state == ST_CALC) || (state == ST_FIX);
    assign mdu.done_o     = (state == ST_DONE) && !mdu.annul_i;
    assign mdu.wreg_o     = mdu.done_o;
    assign mdu.result_o   = result_q;
    assign mdu.wd_o       = wd_out;
endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - directed checks of ex_mdu with single-cycle and iterative multiply instances
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mdu_if #(.XLEN(32), .ADDR_W(5)) m0 ();
    ex_mdu_if #(.XLEN(32), .ADDR_W(5)) m1 ();

    ex_mdu #(.XLEN(32), .MUL_ITER(0), .ADDR_W(5)) dut0 (.clk(clk), .rst(rst), .mdu(m0.slave));
    ex_mdu #(.XLEN(32), .MUL_ITER(1), .ADDR_W(5)) dut1 (.clk(clk), .rst(rst), .mdu(m1.slave));

    int errors = 0;
    int checks = 0;
    int lat0, lat1;
    logic [31:0] res0, res1;
    logic [4:0]  wdo0;
    logic        wr0, stl0, iss0, seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic an, input mdu_op_e op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd);
        m0.start_i = st; m0.annul_i = an; m0.op_i = op; m0.rs1_i = a; m0.rs2_i = b; m0.wd_i = wd;
        m1.start_i = st; m1.annul_i = an; m1.op_i = op; m1.rs1_i = a; m1.rs2_i = b; m1.wd_i = wd;
    endtask

    // Called just after a rising edge: issues in cycle 0 and records the done cycle of each DUT.
    task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd);
        drive(1'b1, 1'b0, op, a, b, wd);
        #1 iss0 = m0.stallreq_o;
        lat0 = 0; lat1 = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive(1'b0, 1'b0, op, 32'h0, 32'h0, 5'd0);
            if (m0.done_o && lat0 == 0) begin
                lat0 = c; res0 = m0.result_o; wdo0 = m0.wd_o; wr0 = m0.wreg_o; stl0 = m0.stallreq_o;
            end
            if (m1.done_o && lat1 == 0) begin
                lat1 = c; res1 = m1.result_o;
            end
            if (lat0 != 0 && lat1 != 0) break;
        end
        @(posedge clk); #1;
        check("done_one_cycle", {30'd0, m0.done_o, m1.done_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, MDU_MUL, 32'h0, 32'h0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_done",   {31'd0, m0.done_o},   32'd0);
        check("rst_wreg",   {31'd0, m0.wreg_o},   32'd0);
        check("rst_result", m0.result_o,          32'd0);
        check("rst_wd",     {27'd0, m0.wd_o},     32'd0);
        check("rst_stall",  {31'd0, m0.stallreq_o}, 32'd0);
        check("rst_result1", m1.result_o,         32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // signed divide: iterative path
        run_op(MDU_DIV, 32'hFFFFFFEC, 32'd3, 5'd3);
        check("div_issue_stall", {31'd0, iss0}, 32'd1);
        check("div_lat",    lat0, 32'd34);
        check("div_res",    res0, 32'hFFFFFFFA);
        check("div_wd",     {27'd0, wdo0}, 32'd3);
        check("div_wreg",   {31'd0, wr0}, 32'd1);
        check("div_done_stall", {31'd0, stl0}, 32'd0);
        check("div_lat1",   lat1, 32'd34);
        check("div_res1",   res1, 32'hFFFFFFFA);
        run_op(MDU_REM, 32'hFFFFFFEC, 32'd3, 5'd4);
        check("rem_lat",    lat0, 32'd34);
        check("rem_res",    res0, 32'hFFFFFFFE);
        run_op(MDU_DIV, 32'd20, 32'hFFFFFFFD, 5'd5);
        check("div_pn_res", res0, 32'hFFFFFFFA);
        run_op(MDU_REM, 32'd20, 32'hFFFFFFFD, 5'd5);
        check("rem_pn_res", res0, 32'd2);
        run_op(MDU_DIVU, 32'd100, 32'd7, 5'd6);
        check("divu_res",   res0, 32'd14);
        run_op(MDU_REMU, 32'd100, 32'd7, 5'd6);
        check("remu_res",   res0, 32'd2);

        // divide-by-zero and signed overflow fast paths
        run_op(MDU_DIVU, 32'd7, 32'd0, 5'd7);
        check("divu0_lat",  lat0, 32'd1);
        check("divu0_res",  res0, 32'hFFFFFFFF);
        check("divu0_wd",   {27'd0, wdo0}, 32'd7);
        check("divu0_lat1", lat1, 32'd1);
        run_op(MDU_REMU, 32'd7, 32'd0, 5'd7);
        check("remu0_res",  res0, 32'd7);
        run_op(MDU_DIV, 32'd5, 32'd0, 5'd8);
        check("div0_res",   res0, 32'hFFFFFFFF);
        run_op(MDU_REM, 32'hFFFFFFFB, 32'd0, 5'd8);
        check("rem0_res",   res0, 32'hFFFFFFFB);
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd9);
        check("ovf_div_lat", lat0, 32'd1);
        check("ovf_div_res", res0, 32'h80000000);
        run_op(MDU_REM, 32'h80000000, 32'hFFFFFFFF, 5'd9);
        check("ovf_rem_res", res0, 32'd0);

        // multiplies on both instances
        run_op(MDU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
        check("mulh_lat0", lat0, 32'd1);
        check("mulh_lat1", lat1, 32'd34);
        check("mulh_res0", res0, 32'd0);
        check("mulh_res1", res1, 32'd0);
        run_op(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
        check("mulhu_res0", res0, 32'hFFFFFFFE);
        check("mulhu_res1", res1, 32'hFFFFFFFE);
        run_op(MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
        check("mulhsu_res0", res0, 32'hFFFFFFFF);
        check("mulhsu_res1", res1, 32'hFFFFFFFF);
        run_op(MDU_MUL, 32'h12345678, 32'h10, 5'd2);
        check("mul_res0", res0, 32'h23456780);
        check("mul_res1", res1, 32'h23456780);
        run_op(MDU_MULH, 32'h80000000, 32'h80000000, 5'd2);
        check("mulh_mn_res0", res0, 32'h40000000);
        check("mulh_mn_res1", res1, 32'h40000000);
        run_op(MDU_MULHSU, 32'hFFFFFFFE, 32'd3, 5'd2);
        check("mulhsu_neg_res0", res0, 32'hFFFFFFFF);
        check("mulhsu_neg_res1", res1, 32'hFFFFFFFF);
        run_op(MDU_MUL, 32'd7, 32'hFFFFFFFD, 5'd2);
        check("mul_neg_res0", res0, 32'hFFFFFFEB);
        check("mul_neg_res1", res1, 32'hFFFFFFEB);
        repeat (3) @(posedge clk);
        #1 check("result_hold", m0.result_o, 32'hFFFFFFEB);

        // annul mid-divide, then a fresh op in the following cycle
        drive(1'b1, 1'b0, MDU_DIV, 32'hFFFFFFEC, 32'd3, 5'd12);
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive(1'b0, 1'b0, MDU_DIV, 32'h0, 32'h0, 5'd0);
            if (c == 5) check("calc_stall", {31'd0, m0.stallreq_o}, 32'd1);
            if (m0.done_o || m1.done_o) seen = 1'b1;
            if (c == 10) begin m0.annul_i = 1'b1; m1.annul_i = 1'b1; end
        end
        @(posedge clk); #1;
        m0.annul_i = 1'b0; m1.annul_i = 1'b0;
        #1;
        check("annul_no_done", {31'd0, seen}, 32'd0);
        check("annul_stall",  {30'd0, m0.stallreq_o, m1.stallreq_o}, 32'd0);
        run_op(MDU_DIVU, 32'd100, 32'd7, 5'd10);
        check("post_annul_lat", lat0, 32'd34);
        check("post_annul_res", res0, 32'd14);
        check("post_annul_wd",  {27'd0, wdo0}, 32'd10);

        // start held high during CALC with other operands must be ignored
        drive(1'b1, 1'b0, MDU_DIVU, 32'd100, 32'd7, 5'd11);
        lat0 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive(1'b1, 1'b0, MDU_DIVU, 32'd9, 32'd2, 5'd12);
            if (m0.done_o) begin
                lat0 = c; res0 = m0.result_o; wdo0 = m0.wd_o;
                drive(1'b0, 1'b0, MDU_DIVU, 32'h0, 32'h0, 5'd0);
                break;
            end
        end
        check("hold_lat", lat0, 32'd34);
        check("hold_res", res0, 32'd14);
        check("hold_wd",  {27'd0, wdo0}, 32'd11);
        @(posedge clk); #1;

        // reset asserted in cycle 5 of an op clears everything next cycle
        drive(1'b1, 1'b0, MDU_DIV, 32'hFFFFFFEC, 32'd3, 5'd13);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive(1'b0, 1'b0, MDU_DIV, 32'h0, 32'h0, 5'd0);
            if (c == 5) rst = 1'b1;
        end
        @(posedge clk); #1;
        check("midrst_done",   {31'd0, m0.done_o}, 32'd0);
        check("midrst_stall",  {31'd0, m0.stallreq_o}, 32'd0);
        check("midrst_result", m0.result_o, 32'd0);
        check("midrst_wd",     {27'd0, m0.wd_o}, 32'd0);
        rst = 1'b0;
        run_op(MDU_REMU, 32'd100, 32'd7, 5'd14);
        check("after_rst_lat", lat0, 32'd34);
        check("after_rst_res", res0, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
